// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared constants and FSM state type for the nibble-serial add controller
package add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_add_ctrl.sv
// rtl/nibble_serial_add_ctrl.sv - streams a W-bit add one nibble per cycle through an external 4-bit adder
module nibble_serial_add_ctrl
  import add_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] in_a,
  input  logic [NIBBLE_W*NIBBLES-1:0] in_b,
  input  logic                      in_cin,
  output logic [NIBBLE_W-1:0]       add_a,
  output logic [NIBBLE_W-1:0]       add_b,
  output logic                      add_cin,
  input  logic [NIBBLE_W-1:0]       add_sum,
  input  logic                      add_cout,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] out_sum,
  output logic                      out_cout
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t           state, next_state;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     a_reg, b_reg, sum_reg;
  logic             carry_reg;
  logic             last_nibble;

  assign last_nibble = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid) next_state = RUN;
      RUN:     if (last_nibble) next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Handshake flags come only from registered state; adder inputs are quiet outside RUN.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    case (state)
      IDLE: in_ready = 1'b1;
      RUN: begin
        add_a   = a_reg[NIBBLE_W*idx +: NIBBLE_W];
        add_b   = b_reg[NIBBLE_W*idx +: NIBBLE_W];
        add_cin = carry_reg;
      end
      DONE:    out_valid = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= in_a;
            b_reg     <= in_b;
            carry_reg <= in_cin;
            idx       <= '0;
          end
        end
        RUN: begin
          sum_reg[NIBBLE_W*idx +: NIBBLE_W] <= add_sum;
          carry_reg                         <= add_cout;
          if (!last_nibble) idx <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_sum  = sum_reg;
  assign out_cout = carry_reg;

endmodule
